mux_nto1_reg: RTL and testbench

Parametrised, registered N-to-1, W-bit multiplexer; successor to the team's single-bit 2:1 mux.
Channel changes use a valid/ready select handshake. Each real switch inserts a programmable blanking gap so downstream logic never samples a mixed or transitional value.
Sits between parallel sample sources (ADC lanes, test-pattern generators) and a single downstream consumer.

---
 rtl/mux_pkg.sv | 23 ++
 rtl/mux_hold_timer.sv | 26 ++
 rtl/mux_nto1_reg.sv | 110 +++++++++++
 tb/tb_mux_nto1_reg.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and width helpers for the registered N:1 mux and its timer.
package mux_pkg;

  typedef enum logic {PASS = 1'b0, SWITCH = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;
  localparam int DEF_HOLD  = 2;
  localparam int DEF_DWELL = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_hold_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module mux_hold_timer
  import mux_pkg::*;
#(
  parameter int             CW      = 1,
  parameter logic [CW-1:0]  RST_VAL = '0
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= RST_VAL;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N:1, W-bit mux with select handshake and blanking on channel change.
// Optional round-robin autoscan is enabled by defining MUX_AUTOSCAN_EN.
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int HOLD  = DEF_HOLD,
`ifdef MUX_AUTOSCAN_EN
  parameter int DWELL = DEF_DWELL,
`endif
  localparam int SELW = cw(NCH)
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel_req,
  input  logic                 sel_valid,
`ifdef MUX_AUTOSCAN_EN
  input  logic                 scan_en,
`endif
  output logic                 sel_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [SELW-1:0]      cur_sel,
  output logic                 sel_err
);

  localparam int             HW   = cw(HOLD);
  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  logic [NCH-1:0][WIDTH-1:0] ch;
  state_t                    state, state_nxt;
  logic                      acc, bad, go, hold_done;
  logic [SELW-1:0]           go_sel;

  assign ch = din;

`ifdef MUX_AUTOSCAN_EN
  localparam int DW = cw(DWELL);
  logic dwell_done;

  // Dwell restarts on every entry to PASS and is held full while scan is off.
  mux_hold_timer #(.CW(DW), .RST_VAL(DW'(DWELL - 1))) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (!scan_en || (state == SWITCH && hold_done)),
    .load_val (DW'(DWELL - 1)),
    .en       (scan_en && state == PASS),
    .done     (dwell_done)
  );

  assign sel_ready = (state == PASS) && !rst && !scan_en;
`else
  assign sel_ready = (state == PASS) && !rst;
`endif

  mux_hold_timer #(.CW(HW)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (go),
    .load_val (HW'(HOLD - 1)),
    .en       (state == SWITCH),
    .done     (hold_done)
  );

  always_comb begin
    acc       = sel_valid && sel_ready;
    bad       = acc && (int'(sel_req) >= NCH);
    go        = acc && !bad && (sel_req != cur_sel);
    go_sel    = sel_req;
`ifdef MUX_AUTOSCAN_EN
    if (scan_en && state == PASS && dwell_done) begin
      go     = 1'b1;
      go_sel = (cur_sel == LAST) ? '0 : cur_sel + 1'b1;
    end
`endif
    state_nxt = state;
    case (state)
      PASS:    if (go)        state_nxt = SWITCH;
      SWITCH:  if (hold_done) state_nxt = PASS;
      default:                state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= PASS;
    else     state <= state_nxt;
  end

  // dout freezes through SWITCH so the consumer never sees the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= bad;
      if (go) cur_sel <= go_sel;
      if (state == PASS) begin
        dout       <= ch[cur_sel];
        dout_valid <= 1'b1;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed scoreboard bench for mux_nto1_reg (NCH=3, HOLD=2; autoscan steps when MUX_AUTOSCAN_EN).
module tb_mux_nto1_reg;

  localparam int W = 8;
  localparam int N = 3;
  localparam int H = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] din;
  logic [1:0]     sel_req = 2'd0;
  logic           sel_valid = 1'b0;
  logic           sel_ready;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic [1:0]     cur_sel;
  logic           sel_err;
`ifdef MUX_AUTOSCAN_EN
  logic           scan_en = 1'b0;
`endif

  always #5 clk = ~clk;

  mux_nto1_reg #(
    .WIDTH (W),
    .NCH   (N),
    .HOLD  (H)
`ifdef MUX_AUTOSCAN_EN
    , .DWELL (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel_req    (sel_req),
    .sel_valid  (sel_valid),
`ifdef MUX_AUTOSCAN_EN
    .scan_en    (scan_en),
`endif
    .sel_ready  (sel_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .cur_sel    (cur_sel),
    .sel_err    (sel_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] s;
    logic       e;
    logic       r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Push the expectation for the coming edge, advance one clock, pop and compare.
  task automatic cyc(input int d, input int v, input int s, input int e, input int r);
    exp_t x;
    x.d = 8'(d); x.v = 1'(v); x.s = 2'(s); x.e = 1'(e); x.r = 1'(r);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("dout",       dout,               x.d);
    chk("dout_valid", 8'(dout_valid),     8'(x.v));
    chk("cur_sel",    8'(cur_sel),        8'(x.s));
    chk("sel_err",    8'(sel_err),        8'(x.e));
    chk("sel_ready",  8'(sel_ready),      8'(x.r));
  endtask

  initial begin
    din = {8'h3C, 8'h5A, 8'hA5};

    // Reset held for three edges
    repeat (3) cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("ready_first_cycle", 8'(sel_ready), 8'd1);
    chk("dout_first_cycle",  dout,          8'h00);
    repeat (2) cyc('hA5, 1, 0, 0, 1);

    // Real switch ch0 -> ch2: two blank cycles, dout frozen at the old value
    sel_valid = 1'b1; sel_req = 2'd2;
    cyc('hA5, 1, 2, 0, 0);
    sel_valid = 1'b0;
    din[7:0] = 8'h11;
    cyc('hA5, 0, 2, 0, 0);
    cyc('hA5, 0, 2, 0, 1);
    cyc('h3C, 1, 2, 0, 1);

    // Out-of-range request: one-cycle error, nothing else moves
    sel_valid = 1'b1; sel_req = 2'd3;
    cyc('h3C, 1, 2, 1, 1);
    sel_valid = 1'b0;
    cyc('h3C, 1, 2, 0, 1);

    // Request of the current channel is a no-op
    sel_valid = 1'b1; sel_req = 2'd2;
    cyc('h3C, 1, 2, 0, 1);
    sel_valid = 1'b0;
    cyc('h3C, 1, 2, 0, 1);

    // Switch to ch1, keep requesting ch0 through the blank: ignored
    sel_valid = 1'b1; sel_req = 2'd1;
    cyc('h3C, 1, 1, 0, 0);
    sel_req = 2'd0;
    cyc('h3C, 0, 1, 0, 0);
    cyc('h3C, 0, 1, 0, 1);
    sel_valid = 1'b0;
    cyc('h5A, 1, 1, 0, 1);

    // Reset during the second blank cycle of a ch1 -> ch2 switch
    sel_valid = 1'b1; sel_req = 2'd2;
    cyc('h5A, 1, 2, 0, 0);
    sel_valid = 1'b0;
    cyc('h5A, 0, 2, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc('h11, 1, 0, 0, 1);

`ifdef MUX_AUTOSCAN_EN
    begin
      logic [7:0] dv [3];
      int         prev;
      dv[0] = 8'h11; dv[1] = 8'h5A; dv[2] = 8'h3C;
      prev  = 'h11;
      scan_en = 1'b1;
      repeat (3) cyc(prev, 1, 0, 0, 0);
      for (int r = 0; r < 3; r++) begin
        int nxt;
        nxt = (r + 1) % 3;
        cyc(prev, 1, nxt, 0, 0);
        repeat (2) cyc(prev, 0, nxt, 0, 0);
        repeat (3) cyc(int'(dv[nxt]), 1, nxt, 0, 0);
        prev = int'(dv[nxt]);
      end
      scan_en = 1'b0;
      cyc('h11, 1, 0, 0, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
